fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Write-side arbiter for the 8-deep, 8-bit `async_fifo`. It shares the FIFO write port among `N_REQ` producers in the `wrclk` domain using round-robin bursts. It drives `wrreq`/`data` from registers and never writes into a full FIFO, counting space from `wrfull`/`wrusedw` plus writes still in flight. It sits between the producer blocks and the FIFO's write port; the read side is untouched.

## Interface
- `N_REQ`, 4: number of requesters (2..8)
- `DATA_W`, 8: word width; must match the FIFO `data` width
- `DEPTH`, 8: FIFO capacity in words
- `BURST_LEN`, 4: maximum words per grant (1..15)
- `STATUS_LAT`, 1: `wrclk` cycles from a `wrreq` pulse until `wrusedw`/`wrfull` reflect it (0..3)

Ports:
- `wrclk`  in  1  write-domain clock; all logic on its rising edge
- `aclr_n`  in  1  asynchronous active-low reset
- `req_valid`  in  N_REQ  requester i has a word on its slice of `req_data`
- `req_data`  in  N_REQ*DATA_W  word of requester i at bits `[i*DATA_W +: DATA_W]`
- `req_ready`  out  N_REQ  combinational; the word of requester i is accepted this cycle
- `wrfull`  in  1  from FIFO
- `wrusedw`  in  $clog2(DEPTH)  from FIFO
- `wrreq`  out  1  registered FIFO write strobe
- `data`  out  DATA_W  registered FIFO write data
- `grant_id`  out  $clog2(N_REQ)  current owner; valid while `busy`
- `busy`  out  1  a requester holds the grant
- `stall_cnt`  out  16  saturating count of owner-blocked cycles

## Operation
- Occupancy `occ` = `DEPTH` when `wrfull` is high, otherwise `wrusedw`.
- `inflight` = number of `wrreq` pulses issued in the last `STATUS_LAT`+1 cycles, taken from a shift register of `wrreq` history.
- `space` = (`occ` + `inflight` < `DEPTH`).
- States:
  - IDLE: if any `req_valid`, pick the first valid index at or after `rr_ptr`, cyclically. Load `grant_id`, clear `beat_cnt`, go to BURST. No word is accepted in IDLE.
  - BURST: `req_ready[grant_id]` = `req_valid[grant_id]` & `space`; every other `req_ready` bit is 0.
    - On accept: `wrreq`<=1, `data`<=owner word, `beat_cnt`++.
    - Exit to IDLE and set `rr_ptr`<=`grant_id`+1 (mod `N_REQ`) when the owner's `req_valid` is low, or when an accept makes `beat_cnt` reach `BURST_LEN`.
- `wrreq`<=0 in every cycle without an accept. `data` holds its last value.
- `stall_cnt` increments, saturating at 0xFFFF, in each BURST cycle with `req_valid[grant_id]`=1 and `space`=0. Only reset clears it.
- While stalled the grant is held. It does not rotate, so a full FIFO never reorders words of one burst.
- Requesters must hold `req_valid`/`req_data` stable until `req_ready` is seen.

## Timing
- Reset (`aclr_n` low, asynchronous) sets:
  - state IDLE, `wrreq`=0, `data`=0, `grant_id`=0, `busy`=0
  - `rr_ptr`=0, `beat_cnt`=0, `inflight` history=0, `stall_cnt`=0
  - `req_ready` low
- Reset asserted mid-burst drops the burst. No partial `wrreq` is emitted after reset deasserts.
- Latency:
  - valid in IDLE → grant: 1 cycle
  - accept → `wrreq`/`data` at the FIFO: the next edge
  - minimum request-to-FIFO-write time: 2 cycles
- Peak rate: one word per cycle within a burst, with one idle cycle between bursts.
- `busy`=1 exactly in BURST.
- Boundaries:
  - `occ`=DEPTH-1 with `inflight`=1 → `space`=0. No overflow is possible.
  - `rr_ptr` wraps from `N_REQ`-1 to 0.
  - Single valid requester: it is re-granted after one IDLE cycle.

## Structure
- Shared package `fifo_pkg`:
  - `FIFO_DEPTH`=8, `FIFO_DATA_W`=8, `FIFO_USEDW_W`=3
  - state encoding `ARB_IDLE`, `ARB_BURST`
- Sub-module `rr_pick`: combinational round-robin selector taking (`req_valid`, `rr_ptr`) and returning (`found`, `index`).
- Everything else lives in `fifo_wr_arbiter`.

## Test plan
- **Reset values:** hold `aclr_n`=0 for 5 cycles → all outputs 0; assert `aclr_n` low mid-burst → `wrreq` drops to 0 asynchronously.
- **Single requester:** requester 0 streams 0x00..0x05 with the FIFO empty and drained → FIFO receives 0x00..0x05 in order, bursts of 4+2, one bubble between bursts, `stall_cnt`=0.
- **Round-robin:** all 4 requesters valid continuously with `BURST_LEN`=4 → `grant_id` sequence 0,1,2,3,0; each burst writes 4 words.
- **Full FIFO:** no reader, requester 2 sends 10 words → exactly 8 writes, `wrreq` never high while `wrfull`=1, `stall_cnt` increments each following cycle; then drain 3 words → remaining 2 words written in order.
- **Early end and wrap:** requester 3 drops valid after 1 word while requester 1 is valid → IDLE, `rr_ptr` wraps to 0, requester 1 is granted next.
- **Latency check:** `STATUS_LAT`=2 with a model FIFO that delays `wrusedw` by 2 cycles → no overflow at `occ`=6 with 2 writes in flight.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the async_fifo write side: FIFO geometry, arbiter
// state encoding and a small cyclic-index helper.
package fifo_pkg;

    localparam int FIFO_DEPTH   = 8;
    localparam int FIFO_DATA_W  = 8;
    localparam int FIFO_USEDW_W = 3;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // (base + off) modulo n, for walking requester indices cyclically.
    function automatic int wrap_add(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid requester at or after
// rr_ptr, searching cyclically.
module rr_pick
    import fifo_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    // Scan from the farthest offset back towards rr_ptr so the nearest valid index wins.
    always_comb begin
        // NOTE: every output gets a default before the loop; otherwise paths that
        // find nothing would leave found/index unassigned and infer latches.
        found = 1'b0;
        index = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(int'(rr_ptr), k, N_REQ)]) begin
                found = 1'b1;
                index = IDX_W'(wrap_add(int'(rr_ptr), k, N_REQ));
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for async_fifo: shares the FIFO write port among N_REQ
// producers in round-robin bursts and never writes into a full FIFO, counting
// both the reported occupancy and writes the FIFO status has not caught up with.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_W     = FIFO_DATA_W,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int BURST_LEN  = 4,
    parameter int STATUS_LAT = 1
) (
    input  logic                       wrclk,
    input  logic                       aclr_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       wrfull,
    input  logic [$clog2(DEPTH)-1:0]   wrusedw,
    output logic                       wrreq,
    output logic [DATA_W-1:0]          data,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic [15:0]                stall_cnt
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int BEAT_W = 4;

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [BEAT_W-1:0]  beat_cnt;
    // Bit k is set when wrreq was high k cycles ago; bit 0 mirrors wrreq itself.
    logic [STATUS_LAT:0] wr_hist;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_valid;
    logic [DATA_W-1:0]  owner_word;
    logic               space;
    logic               accept;
    logic               stall;
    logic               load_grant;
    logic               burst_done;
    int                 occ;
    int                 inflight;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .found     (pick_found),
        .index     (pick_idx)
    );

    assign owner_valid = req_valid[grant_id];
    assign owner_word  = req_data[int'(grant_id)*DATA_W +: DATA_W];
    assign busy        = (state == ARB_BURST);

    // Free-space test: reported occupancy plus writes not yet visible in wrusedw/wrfull.
    always_comb begin
        occ      = wrfull ? DEPTH : int'(wrusedw);
        inflight = $countones(wr_hist);
        space    = (occ + inflight) < DEPTH;
    end

    // FSM state register.
    always_ff @(posedge wrclk or negedge aclr_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!aclr_n) state <= ARB_IDLE;
        else         state <= state_nxt;
    end

    // Next state, ready handshake and burst control strobes.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        accept     = 1'b0;
        stall      = 1'b0;
        load_grant = 1'b0;
        burst_done = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    load_grant = 1'b1;
                    state_nxt  = ARB_BURST;
                end
            end
            ARB_BURST: begin
                accept              = owner_valid && space;
                stall               = owner_valid && !space;
                req_ready[grant_id] = accept;
                // A stalled owner keeps the grant so a burst is never split by a full FIFO.
                if (!owner_valid || (accept && beat_cnt == BEAT_W'(BURST_LEN - 1))) begin
                    burst_done = 1'b1;
                    state_nxt  = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Grant owner, beat counter and round-robin pointer.
    always_ff @(posedge wrclk or negedge aclr_n) begin
        if (!aclr_n) begin
            grant_id <= '0;
            beat_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            if (load_grant) begin
                grant_id <= pick_idx;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (burst_done) rr_ptr <= IDX_W'(wrap_add(int'(grant_id), 1, N_REQ));
        end
    end

    // Registered FIFO write port; data holds its last value between writes.
    always_ff @(posedge wrclk or negedge aclr_n) begin
        if (!aclr_n) begin
            wrreq <= 1'b0;
            data  <= '0;
        end else begin
            wrreq <= accept;
            if (accept) data <= owner_word;
        end
    end

    // History of write strobes covering the FIFO status latency.
    always_ff @(posedge wrclk or negedge aclr_n) begin
        // NOTE: this history is a few control flops, so it takes the async reset;
        // a payload storage array would be left unreset.
        if (!aclr_n) begin
            wr_hist <= '0;
        end else begin
            wr_hist[0] <= accept;
            for (int i = 1; i <= STATUS_LAT; i++) wr_hist[i] <= wr_hist[i-1];
        end
    end

    // Saturating count of cycles the owner had data but the FIFO had no room.
    always_ff @(posedge wrclk or negedge aclr_n) begin
        if (!aclr_n)                         stall_cnt <= '0;
        else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: two instances (status latency 1 and 2),
// each with a simple FIFO model behind it and producer models in front.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic wrclk = 1'b0;
    logic aclr_n;
    always #5 wrclk = ~wrclk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- instance 1: N_REQ=4, STATUS_LAT=1 ----------------
    logic [N-1:0]    req_valid, req_ready;
    logic [N*DW-1:0] req_data;
    logic            wrfull, wrreq;
    logic [2:0]      wrusedw;
    logic [7:0]      data;
    logic [1:0]      grant_id;
    logic            busy;
    logic [15:0]     stall_cnt;

    fifo_wr_arbiter #(
        .N_REQ(4), .DATA_W(8), .DEPTH(8), .BURST_LEN(4), .STATUS_LAT(1)
    ) dut (
        .wrclk(wrclk), .aclr_n(aclr_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .wrfull(wrfull), .wrusedw(wrusedw), .wrreq(wrreq),
        .data(data), .grant_id(grant_id), .busy(busy), .stall_cnt(stall_cnt)
    );

    // ---------------- instance 2: N_REQ=2, STATUS_LAT=2 ----------------
    logic [1:0]  req_valid2, req_ready2;
    logic [15:0] req_data2;
    logic        wrfull2, wrreq2;
    logic [2:0]  wrusedw2;
    logic [7:0]  data2;
    logic [0:0]  grant_id2;
    logic        busy2;
    logic [15:0] stall_cnt2;

    fifo_wr_arbiter #(
        .N_REQ(2), .DATA_W(8), .DEPTH(8), .BURST_LEN(4), .STATUS_LAT(2)
    ) dut2 (
        .wrclk(wrclk), .aclr_n(aclr_n), .req_valid(req_valid2), .req_data(req_data2),
        .req_ready(req_ready2), .wrfull(wrfull2), .wrusedw(wrusedw2), .wrreq(wrreq2),
        .data(data2), .grant_id(grant_id2), .busy(busy2), .stall_cnt(stall_cnt2)
    );

    // ---------------- producers ----------------
    // p_idx advances only in the producer process; main sets p_base/p_end.
    int         p_idx [N];
    int         p_end [N];
    logic [7:0] p_base[N];
    int         q_idx = 0;
    int         q_end = 0;
    logic [7:0] q_base = 8'h00;
    logic [N-1:0] acc;
    logic [1:0]   acc2;

    for (genvar g = 0; g < N; g++) begin : g_prod
        assign req_valid[g]           = p_idx[g] < p_end[g];
        assign req_data[g*DW +: DW]   = p_base[g] + 8'(p_idx[g]);
    end
    assign req_valid2 = {1'b0, q_idx < q_end};
    assign req_data2  = {8'h00, q_base + 8'(q_idx)};

    initial begin
        forever begin
            @(negedge wrclk);
            acc  = req_ready;
            acc2 = req_ready2;
            @(posedge wrclk);
            #1;
            for (int i = 0; i < N; i++) if (acc[i]) p_idx[i]++;
            if (acc2[0]) q_idx++;
        end
    end

    // ---------------- FIFO model 1: status one cycle after the write ----------------
    logic [3:0] f_cnt = 4'd0;
    logic [7:0] f_q[$];
    logic [7:0] wr_log[$];
    int         wr_cyc[$];
    logic [7:0] rd_log[$];
    int         ovf = 0;
    int         cyc = 0;
    logic       rd_auto = 1'b0;
    logic       rd_en   = 1'b0;
    logic       wr_ok, rd_ok;

    assign wrusedw = f_cnt[2:0];
    assign wrfull  = f_cnt[3];
    assign wr_ok   = wrreq && (f_cnt != 4'd8);
    assign rd_ok   = (rd_auto || rd_en) && (f_cnt != 4'd0);

    always @(posedge wrclk) begin
        cyc <= cyc + 1;
        if (wrreq && !wr_ok) ovf <= ovf + 1;
        if (wr_ok) begin
            f_q.push_back(data);
            wr_log.push_back(data);
            wr_cyc.push_back(cyc);
        end
        if (rd_ok) rd_log.push_back(f_q.pop_front());
        f_cnt <= f_cnt + {3'b000, wr_ok} - {3'b000, rd_ok};
    end

    // ---------------- FIFO model 2: status two cycles after the write, no reader ----------------
    logic [3:0] g_cnt = 4'd0;
    logic [3:0] g_st  = 4'd0;
    logic [7:0] wr2_log[$];
    int         ovf2 = 0;
    logic       wr2_ok;

    assign wrusedw2 = g_st[2:0];
    assign wrfull2  = g_st[3];
    assign wr2_ok   = wrreq2 && (g_cnt != 4'd8);

    always @(posedge wrclk) begin
        if (wrreq2 && !wr2_ok) ovf2 <= ovf2 + 1;
        if (wr2_ok) wr2_log.push_back(data2);
        g_cnt <= g_cnt + {3'b000, wr2_ok};
        g_st  <= g_cnt;
    end

    // ---------------- grant monitor ----------------
    logic       busy_q = 1'b0;
    logic [1:0] grant_log[$];
    always @(negedge wrclk) begin
        if (busy && !busy_q) grant_log.push_back(grant_id);
        busy_q <= busy;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int i, input logic [7:0] first, input int n);
        p_base[i] = first - 8'(p_idx[i]);
        p_end[i]  = p_idx[i] + n;
    endtask

    function automatic logic [31:0] wl(input int k);
        if (k < wr_log.size()) return 32'(wr_log[k]);
        return 32'hDEAD;
    endfunction
    function automatic logic [31:0] wc(input int k);
        if (k < wr_cyc.size()) return 32'(wr_cyc[k]);
        return 32'hDEAD;
    endfunction
    function automatic logic [31:0] gl(input int k);
        if (k < grant_log.size()) return 32'(grant_log[k]);
        return 32'hDEAD;
    endfunction
    function automatic logic [31:0] rl(input int k);
        if (k < rd_log.size()) return 32'(rd_log[k]);
        return 32'hDEAD;
    endfunction
    function automatic logic [31:0] w2(input int k);
        if (k < wr2_log.size()) return 32'(wr2_log[k]);
        return 32'hDEAD;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int mark, mark_g, mark_r, cyc0, s1, t;
        int gaps[5] = '{1, 1, 1, 2, 1};
        int rr_exp[5] = '{0, 1, 2, 3, 0};

        for (int i = 0; i < N; i++) begin
            p_base[i] = 8'h00;
            p_end[i]  = 0;
        end
        aclr_n = 1'b0;

        // Reset values, with all requesters already presenting data.
        @(negedge wrclk);
        for (int i = 0; i < N; i++) load(i, 8'(i << 4), 8);
        rd_auto = 1'b1;
        repeat (4) @(negedge wrclk);
        check("rst_wrreq",     32'(wrreq),     0);
        check("rst_data",      32'(data),      0);
        check("rst_grant_id",  32'(grant_id),  0);
        check("rst_busy",      32'(busy),      0);
        check("rst_stall_cnt", 32'(stall_cnt), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_wrreq2",    32'(wrreq2),    0);

        // Round-robin: 4 requesters x 8 words, bursts of 4.
        mark   = wr_log.size();
        mark_g = grant_log.size();
        aclr_n = 1'b1;
        repeat (60) @(negedge wrclk);
        for (int k = 0; k < 5; k++) check("rr_grant", gl(mark_g + k), 32'(rr_exp[k]));
        check("rr_count", 32'(wr_log.size() - mark), 32);
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < 4; k++)
                check("rr_word", wl(mark + b*4 + k), 32'(((b % 4) << 4) + (b / 4) * 4 + k));

        // Single requester 0 streams 0x00..0x05: 4+2 with one bubble.
        mark   = wr_log.size();
        mark_g = grant_log.size();
        cyc0   = cyc;
        load(0, 8'h00, 6);
        repeat (20) @(negedge wrclk);
        check("single_count", 32'(wr_log.size() - mark), 6);
        for (int k = 0; k < 6; k++) check("single_word", wl(mark + k), 32'(k));
        check("single_latency", wc(mark) - 32'(cyc0), 2);
        for (int k = 0; k < 5; k++) check("single_gap", wc(mark + k + 1) - wc(mark + k), 32'(gaps[k]));
        check("single_regrant", gl(mark_g + 1), 0);
        check("single_stall", 32'(stall_cnt), 0);

        // Early end and pointer wrap: requester 3 sends one word, then requester 1.
        mark   = wr_log.size();
        mark_g = grant_log.size();
        load(3, 8'h3C, 1);
        t = 0;
        while (!busy && t < 50) begin
            @(negedge wrclk);
            t++;
        end
        check("early_grant_seen", 32'(busy), 1);
        load(1, 8'h1A, 2);
        repeat (15) @(negedge wrclk);
        check("early_first_grant", gl(mark_g),     3);
        check("early_next_grant",  gl(mark_g + 1), 1);
        check("early_word0", wl(mark),     32'h3C);
        check("early_word1", wl(mark + 1), 32'h1A);
        check("early_word2", wl(mark + 2), 32'h1B);

        // Full FIFO: no reader, requester 2 sends 10 words.
        check("full_start_empty", 32'({wrfull, wrusedw}), 0);
        rd_auto = 1'b0;
        mark    = wr_log.size();
        mark_r  = rd_log.size();
        load(2, 8'hA0, 10);
        repeat (40) @(negedge wrclk);
        check("full_writes",   32'(wr_log.size() - mark), 8);
        check("full_wrfull",   32'(wrfull),   1);
        check("full_busy",     32'(busy),     1);
        check("full_grant_id", 32'(grant_id), 2);
        check("full_overflow", 32'(ovf),      0);
        s1 = int'(stall_cnt);
        repeat (10) @(negedge wrclk);
        check("full_stall_rate", 32'(int'(stall_cnt) - s1), 10);
        rd_en = 1'b1;
        repeat (3) @(negedge wrclk);
        rd_en = 1'b0;
        repeat (20) @(negedge wrclk);
        for (int k = 0; k < 3; k++) check("full_drain_word", rl(mark_r + k), 32'(8'hA0 + k));
        check("full_total_writes", 32'(wr_log.size() - mark), 10);
        check("full_tail0", wl(mark + 8), 32'hA8);
        check("full_tail1", wl(mark + 9), 32'hA9);
        check("full_overflow_end", 32'(ovf), 0);
        check("full_idle_after", 32'(busy), 0);

        // Status latency 2: no overflow with writes still in flight.
        q_base = 8'hC0 - 8'(q_idx);
        q_end  = q_idx + 10;
        repeat (60) @(negedge wrclk);
        check("lat2_writes",   32'(wr2_log.size()), 8);
        check("lat2_overflow", 32'(ovf2), 0);
        check("lat2_wrfull",   32'(wrfull2), 1);
        check("lat2_last",     w2(7), 32'hC7);
        check("lat2_busy",     32'(busy2), 1);
        check("lat2_stalled",  32'(stall_cnt2 != 16'd0), 1);

        // Reset asserted mid-burst.
        rd_auto = 1'b1;
        load(1, 8'h50, 20);
        t = 0;
        while (!wrreq && t < 40) begin
            @(negedge wrclk);
            t++;
        end
        check("mid_wrreq_seen", 32'(wrreq), 1);
        aclr_n = 1'b0;
        #1;
        check("mid_rst_wrreq",     32'(wrreq),      0);
        check("mid_rst_busy",      32'(busy),       0);
        check("mid_rst_req_ready", 32'(req_ready),  0);
        check("mid_rst_data",      32'(data),       0);
        check("mid_rst_stall",     32'(stall_cnt),  0);
        check("mid_rst_stall2",    32'(stall_cnt2), 0);
        for (int i = 0; i < N; i++) p_end[i] = p_idx[i];
        q_end = q_idx;
        repeat (2) @(negedge wrclk);
        mark   = wr_log.size();
        aclr_n = 1'b1;
        repeat (6) @(negedge wrclk);
        check("mid_no_write_after", 32'(wr_log.size() - mark), 0);
        check("mid_idle_after",     32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
